// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: serializes ELBETH fetch and data requests onto one memory bus, data first.
// Defining ELBETH_MEM_ARB_TIMEOUT_EN adds a bus timeout of TIMEOUT_CYCLES grant cycles.
module elbeth_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] if_imem_addr,
    input  logic                  if_imem_en,
    output logic [DATA_WIDTH-1:0] if_imem_rdata,
    output logic                  if_imem_ready,
    output logic                  if_imem_error,
    input  logic [ADDR_WIDTH-1:0] exs_dmem_addr,
    input  logic [DATA_WIDTH-1:0] exs_dmem_wdata,
    input  logic                  exs_dmem_wr,
    input  logic [3:0]            exs_dmem_data_sel,
    input  logic                  exs_dmem_en,
    output logic [DATA_WIDTH-1:0] exs_dmem_rdata,
    output logic                  exs_dmem_ready,
    output logic                  exs_dmem_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr,
    output logic [3:0]            mem_data_sel,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    input  logic                  mem_error,
    output logic                  arb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("elbeth_mem_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [3:0]            mem_data_sel_q, mem_data_sel_d;
    logic                  mem_en_q, mem_en_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  if_error_q, if_error_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  dm_ready_q, dm_ready_d;
    logic                  dm_error_q, dm_error_d;
`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic                  timeout;

    assign timeout = (({1'b0, wait_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wr_d       = mem_wr_q;
        mem_data_sel_d = mem_data_sel_q;
        mem_en_d       = mem_en_q;
        // Response registers are pulses: zero unless the bus cycle finishes this cycle.
        if_rdata_d     = '0;
        if_ready_d     = 1'b0;
        if_error_d     = 1'b0;
        dm_rdata_d     = '0;
        dm_ready_d     = 1'b0;
        dm_error_d     = 1'b0;
`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (exs_dmem_en) begin
                    mem_addr_d     = exs_dmem_addr;
                    mem_wdata_d    = exs_dmem_wdata;
                    mem_wr_d       = exs_dmem_wr;
                    mem_data_sel_d = exs_dmem_data_sel;
                    mem_en_d       = 1'b1;
                    state_d        = GRANT_D;
                end else if (if_imem_en) begin
                    mem_addr_d     = if_imem_addr;
                    mem_wdata_d    = '0;
                    mem_wr_d       = 1'b0;
                    mem_data_sel_d = 4'hF;
                    mem_en_d       = 1'b1;
                    state_d        = GRANT_I;
                end
`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    mem_en_d = 1'b0;
                    state_d  = RESP;
                    if (state_q == GRANT_D) begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = mem_rdata;
                        dm_error_d = mem_error;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                        if_error_d = mem_error;
                    end
                end
`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
                else if (timeout) begin
                    mem_en_d = 1'b0;
                    state_d  = RESP;
                    if (state_q == GRANT_D) begin
                        dm_ready_d = 1'b1;
                        dm_error_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                        if_error_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                // Requests are not sampled here, so the finished request cannot re-enter.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wr_q       <= 1'b0;
            mem_data_sel_q <= 4'h0;
            mem_en_q       <= 1'b0;
            if_rdata_q     <= '0;
            if_ready_q     <= 1'b0;
            if_error_q     <= 1'b0;
            dm_rdata_q     <= '0;
            dm_ready_q     <= 1'b0;
            dm_error_q     <= 1'b0;
`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
            wait_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wr_q       <= mem_wr_d;
            mem_data_sel_q <= mem_data_sel_d;
            mem_en_q       <= mem_en_d;
            if_rdata_q     <= if_rdata_d;
            if_ready_q     <= if_ready_d;
            if_error_q     <= if_error_d;
            dm_rdata_q     <= dm_rdata_d;
            dm_ready_q     <= dm_ready_d;
            dm_error_q     <= dm_error_d;
`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
`endif
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wr         = mem_wr_q;
    assign mem_data_sel   = mem_data_sel_q;
    assign mem_en         = mem_en_q;
    assign if_imem_rdata  = if_rdata_q;
    assign if_imem_ready  = if_ready_q;
    assign if_imem_error  = if_error_q;
    assign exs_dmem_rdata = dm_rdata_q;
    assign exs_dmem_ready = dm_ready_q;
    assign exs_dmem_error = dm_error_q;
    assign arb_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// tb_elbeth_mem_arbiter: directed vector table, hand-written corner sequences and a randomized
// run against a transaction-schedule model of the arbiter.
module tb_elbeth_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] if_imem_addr;
    logic          if_imem_en;
    logic [DW-1:0] if_imem_rdata;
    logic          if_imem_ready;
    logic          if_imem_error;
    logic [AW-1:0] exs_dmem_addr;
    logic [DW-1:0] exs_dmem_wdata;
    logic          exs_dmem_wr;
    logic [3:0]    exs_dmem_data_sel;
    logic          exs_dmem_en;
    logic [DW-1:0] exs_dmem_rdata;
    logic          exs_dmem_ready;
    logic          exs_dmem_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr;
    logic [3:0]    mem_data_sel;
    logic          mem_en;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_error;
    logic          arb_busy;

    elbeth_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_imem_addr(if_imem_addr), .if_imem_en(if_imem_en),
        .if_imem_rdata(if_imem_rdata), .if_imem_ready(if_imem_ready),
        .if_imem_error(if_imem_error),
        .exs_dmem_addr(exs_dmem_addr), .exs_dmem_wdata(exs_dmem_wdata),
        .exs_dmem_wr(exs_dmem_wr), .exs_dmem_data_sel(exs_dmem_data_sel),
        .exs_dmem_en(exs_dmem_en), .exs_dmem_rdata(exs_dmem_rdata),
        .exs_dmem_ready(exs_dmem_ready), .exs_dmem_error(exs_dmem_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_data_sel(mem_data_sel), .mem_en(mem_en), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_error(mem_error), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wr;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] exp_wdata;
        bit          exp_wr;
        logic [3:0]  exp_sel;
        int          exp_lat;
    } vec_t;

    task automatic idle_inputs();
        if_imem_addr = '0; if_imem_en = 1'b0;
        exs_dmem_addr = '0; exs_dmem_wdata = '0; exs_dmem_wr = 1'b0;
        exs_dmem_data_sel = 4'h0; exs_dmem_en = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0; mem_error = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0; idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One request on one port; the bus answers after v.waits extra cycles.
    task automatic run_vec(input vec_t v, input string tag);
        int   cyc, gcnt;
        bit   seen;
        logic rdy, oth;
        @(negedge clk);
        if (v.is_d) begin
            exs_dmem_addr = v.addr; exs_dmem_wdata = v.wdata; exs_dmem_wr = v.wr;
            exs_dmem_data_sel = v.sel; exs_dmem_en = 1'b1;
        end else begin
            if_imem_addr = v.addr; if_imem_en = 1'b1;
            exs_dmem_wdata = 32'hA5A5_5A5A; exs_dmem_wr = 1'b1; exs_dmem_data_sel = 4'h5;
        end
        cyc = 0; gcnt = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = $urandom;
            rdy = v.is_d ? exs_dmem_ready : if_imem_ready;
            oth = v.is_d ? if_imem_ready : exs_dmem_ready;
            if (rdy) begin
                seen = 1'b1;
                chk({tag, "_latency"}, cyc, v.exp_lat);
                chk({tag, "_grant_cycles"}, gcnt, v.waits + 1);
                chk({tag, "_rdata"}, v.is_d ? exs_dmem_rdata : if_imem_rdata, v.rdata);
                chk({tag, "_error"}, v.is_d ? exs_dmem_error : if_imem_error, v.err);
                chk({tag, "_other_ready"}, oth, 0);
                chk({tag, "_mem_en_resp"}, mem_en, 0);
            end else if (mem_en) begin
                gcnt++;
                chk({tag, "_mem_addr"}, mem_addr, v.addr);
                chk({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
                chk({tag, "_mem_wr"}, mem_wr, v.exp_wr);
                chk({tag, "_mem_sel"}, mem_data_sel, v.exp_sel);
                chk({tag, "_other_ready_grant"}, oth, 0);
                if (gcnt == v.waits + 1) begin
                    mem_ready = 1'b1; mem_rdata = v.rdata; mem_error = v.err;
                end
            end
        end
        if (!seen) chk({tag, "_ready_seen"}, 0, 1);
        idle_inputs();
        @(negedge clk);
        chk({tag, "_after_readies"}, {if_imem_ready, exs_dmem_ready}, 0);
        chk({tag, "_after_busy"}, arb_busy, 0);
        chk({tag, "_after_rdata"}, {if_imem_rdata, exs_dmem_rdata}, 0);
        chk({tag, "_after_err"}, {if_imem_error, exs_dmem_error}, 0);
    endtask

    // Random-run model state: one scheduled bus transaction at a time.
    bit          act, pd, d_pend, i_pend, in_g, in_r;
    int          g, w, free_p;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_wr, e_err;
    logic [3:0]  e_sel;

    vec_t vecs[6];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, gcnt, d_at, i_at;
        bit seen;

        vecs[0] = '{0, 32'h100,  32'h0,        0, 4'h0, 0, 32'h0050_0093, 0, 32'h0,        0, 4'hF, 2};
        vecs[1] = '{1, 32'h3000, 32'h1234_5678, 0, 4'hF, 4, 32'hCAFE_F00D, 0, 32'h1234_5678, 0, 4'hF, 6};
        vecs[2] = '{0, 32'h104,  32'h0,        0, 4'h0, 0, 32'h0BAD_BEEF, 1, 32'h0,        0, 4'hF, 2};
        vecs[3] = '{1, 32'h2000, 32'hDEAD_BEEF, 1, 4'h3, 1, 32'h1111_2222, 0, 32'hDEAD_BEEF, 1, 4'h3, 3};
        vecs[4] = '{1, 32'h2004, 32'h0F0F_0F0F, 1, 4'hC, 2, 32'h3333_4444, 1, 32'h0F0F_0F0F, 1, 4'hC, 4};
        vecs[5] = '{0, 32'h208,  32'h0,        0, 4'h0, 3, 32'h8765_4321, 0, 32'h0,        0, 4'hF, 5};

        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_busy", arb_busy, 0);
        chk("reset_readies", {if_imem_ready, exs_dmem_ready}, 0);
        chk("reset_rdata", {if_imem_rdata, exs_dmem_rdata}, 0);
        chk("reset_errors", {if_imem_error, exs_dmem_error}, 0);
        chk("reset_mem_bus", {mem_addr, mem_wr, mem_data_sel}, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a stalled data grant abandons it silently.
        @(negedge clk);
        exs_dmem_addr = 32'h5000; exs_dmem_en = 1'b1; exs_dmem_data_sel = 4'hF;
        repeat (2) @(negedge clk);
        chk("rstmid_granted", mem_en, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_mem_en", mem_en, 0);
        chk("rstmid_busy", arb_busy, 0);
        chk("rstmid_readies", {if_imem_ready, exs_dmem_ready}, 0);
        rst = 1'b1; idle_inputs();
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            mem_ready = 1'b1;
            if (if_imem_ready || exs_dmem_ready || mem_en) seen = 1'b1;
        end
        chk("rstmid_no_late_pulse", seen, 0);
        idle_inputs();

        // Simultaneous requests: data wins, fetch follows three cycles after.
        @(negedge clk);
        exs_dmem_addr = 32'h2000; exs_dmem_wdata = 32'hDEAD_BEEF; exs_dmem_wr = 1'b1;
        exs_dmem_data_sel = 4'b0011; exs_dmem_en = 1'b1;
        if_imem_addr = 32'h100; if_imem_en = 1'b1;
        cyc = 0; d_at = -1; i_at = -1;
        while ((d_at < 0 || i_at < 0) && cyc < 40) begin
            @(negedge clk); cyc++;
            mem_ready = 1'b0; mem_rdata = 32'h600D_0000 + 32'(cyc);
            if (exs_dmem_ready) begin d_at = cyc; exs_dmem_en = 1'b0; end
            if (if_imem_ready) begin i_at = cyc; if_imem_en = 1'b0; end
            if (mem_en) begin
                if (d_at < 0) chk("coll_first_is_data", {mem_addr, mem_wr, mem_data_sel}, {32'h2000, 1'b1, 4'b0011});
                else          chk("coll_second_is_fetch", {mem_addr, mem_wr, mem_data_sel}, {32'h100, 1'b0, 4'hF});
                if (d_at < 0) chk("coll_store_wdata", mem_wdata, 32'hDEAD_BEEF);
                mem_ready = 1'b1;
            end
        end
        chk("coll_data_latency", d_at, 2);
        chk("coll_fetch_gap", i_at - d_at, 3);
        idle_inputs();
        @(negedge clk);

`ifdef ELBETH_MEM_ARB_TIMEOUT_EN
        begin
            vec_t edge_v;
            // mem_ready on the very cycle the counter expires completes normally.
            edge_v = '{1, 32'h4100, 32'h0, 0, 4'hF, TO - 1, 32'h7777_8888, 0, 32'h0, 0, 4'hF, TO + 1};
            run_vec(edge_v, "to_edge");
        end
        @(negedge clk);
        exs_dmem_addr = 32'h4000; exs_dmem_data_sel = 4'hF; exs_dmem_en = 1'b1;
        cyc = 0; gcnt = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
            if (exs_dmem_ready) begin
                seen = 1'b1;
                chk("timeout_grant_cycles", gcnt, TO);
                chk("timeout_error", exs_dmem_error, 1);
                chk("timeout_rdata", exs_dmem_rdata, 0);
            end else if (mem_en) gcnt++;
        end
        chk("timeout_seen", seen, 1);
        idle_inputs();
        @(negedge clk);
`else
        @(negedge clk);
        exs_dmem_addr = 32'h4000; exs_dmem_data_sel = 4'hF; exs_dmem_en = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (exs_dmem_ready) seen = 1'b1;
        end
        chk("notimeout_busy", arb_busy, 1);
        chk("notimeout_mem_en", mem_en, 1);
        chk("notimeout_no_ready", seen, 0);
        do_reset();
        @(negedge clk);
`endif

        // Randomized traffic against a transaction-schedule model.
        idle_inputs();
        act = 0; d_pend = 0; i_pend = 0; free_p = 0; g = 0; w = 0; pd = 0;
        for (int p = 0; p < 1500; p++) begin
            @(negedge clk);
            in_g = act && p >= g && p <= g + w;
            in_r = act && p == g + w + 1;
            chk("rnd_busy", arb_busy, in_g || in_r);
            chk("rnd_mem_en", mem_en, in_g);
            chk("rnd_d_ready", exs_dmem_ready, in_r && pd);
            chk("rnd_i_ready", if_imem_ready, in_r && !pd);
            if (in_g) chk("rnd_bus", {mem_addr, mem_wdata}, {e_addr, e_wdata});
            if (in_g) chk("rnd_ctl", {mem_wr, mem_data_sel}, {e_wr, e_sel});
            if (in_r) chk("rnd_resp", pd ? {exs_dmem_rdata, exs_dmem_error} : {if_imem_rdata, if_imem_error},
                          {e_rdata, e_err});
            if (!in_g && !in_r) chk("rnd_idle_rdata", {if_imem_rdata, exs_dmem_rdata}, 0);

            if (in_g && p == g + w) begin
                mem_ready = 1'b1; mem_rdata = e_rdata; mem_error = e_err;
            end else begin
                mem_ready = in_g ? 1'b0 : 1'($urandom % 2);
                mem_rdata = $urandom; mem_error = 1'($urandom % 2);
            end

            if (in_r) begin
                act = 0; free_p = p + 1;
                if (pd) begin d_pend = 0; exs_dmem_en = 1'b0; end
                else    begin i_pend = 0; if_imem_en = 1'b0; end
            end
            if (in_g && $urandom % 10 == 0) begin
                if (pd) begin exs_dmem_en = 1'b0; exs_dmem_addr = $urandom; exs_dmem_wdata = $urandom; end
                else    begin if_imem_en = 1'b0; if_imem_addr = $urandom; end
            end
            if (!d_pend && $urandom % 3 == 0) begin
                d_pend = 1; exs_dmem_en = 1'b1; exs_dmem_addr = $urandom; exs_dmem_wdata = $urandom;
                exs_dmem_wr = 1'($urandom % 2); exs_dmem_data_sel = 4'($urandom % 16);
            end
            if (!i_pend && $urandom % 3 == 0) begin
                i_pend = 1; if_imem_en = 1'b1; if_imem_addr = $urandom;
            end
            if (!act && p >= free_p && (exs_dmem_en || if_imem_en)) begin
                act = 1; g = p + 1; w = $urandom_range(0, 5); pd = exs_dmem_en;
                e_addr  = pd ? exs_dmem_addr : if_imem_addr;
                e_wdata = pd ? exs_dmem_wdata : 32'h0;
                e_wr    = pd ? exs_dmem_wr : 1'b0;
                e_sel   = pd ? exs_dmem_data_sel : 4'hF;
                e_rdata = $urandom; e_err = ($urandom % 6 == 0);
            end
        end
        idle_inputs();
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elbeth_mem_arbiter.md
Name: elbeth_mem_arbiter

Overview:
Single-port memory arbiter between the instruction-fetch port (if_imem_*) and the data-access port (exs_dmem_*) of the ELBETH core. It serializes both requesters onto one shared memory bus with wait-state support. It returns the request/ready handshake that elbeth_control_unit consumes to generate if_stall and id_stall. Fixed priority: data over fetch.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT_CYCLES, 255, max bus wait cycles before abort (used only with the optional feature; 1..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-low (rst=0 resets on the next rising clk edge)
if_imem_addr  in  ADDR_WIDTH  fetch address
if_imem_en  in  1  fetch request
if_imem_rdata  out  DATA_WIDTH  fetched word, valid with if_imem_ready
if_imem_ready  out  1  one-cycle completion pulse
if_imem_error  out  1  bus error/timeout, valid with if_imem_ready
exs_dmem_addr  in  ADDR_WIDTH  data address
exs_dmem_wdata  in  DATA_WIDTH  store data
exs_dmem_wr  in  1  1=store, 0=load
exs_dmem_data_sel  in  4  byte enables
exs_dmem_en  in  1  data request
exs_dmem_rdata  out  DATA_WIDTH  load data, valid with exs_dmem_ready
exs_dmem_ready  out  1  one-cycle completion pulse
exs_dmem_error  out  1  bus error/timeout, valid with exs_dmem_ready
mem_addr  out  ADDR_WIDTH  shared bus address (registered)
mem_wdata  out  DATA_WIDTH  shared bus write data (registered)
mem_wr  out  1  shared bus write strobe (registered)
mem_data_sel  out  4  shared bus byte enables (registered)
mem_en  out  1  shared bus request (registered)
mem_rdata  in  DATA_WIDTH  bus read data
mem_ready  in  1  bus completion, sampled only while mem_en=1
mem_error  in  1  bus error, sampled with mem_ready
arb_busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; all outputs 0, including the rdata buses. Any in-flight bus cycle is abandoned (mem_en drops). No ready pulse is issued for the abandoned request.
- States: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE transitions:
  - exs_dmem_en=1: latch dmem addr/wdata/wr/data_sel into mem_*; mem_en<=1; go to GRANT_D. This applies even if if_imem_en=1 (data priority).
  - else if_imem_en=1: latch if_imem_addr; mem_wr<=0; mem_data_sel<=4'hF; mem_wdata<=0; mem_en<=1; go to GRANT_I.
  - else remain in IDLE.
- GRANT_x: mem_* held stable.
  - On a cycle with mem_ready=1: capture mem_rdata and mem_error; mem_en<=0; go to RESP.
  - Otherwise wait indefinitely (see Optional Feature).
- RESP (exactly one cycle): the granted port's ready=1, with rdata and error driven from the captured values. The other port's ready=0. Next state is IDLE. In RESP, ready/rdata/error are registered outputs; they return to 0 in IDLE.
- Requester rule: hold en and all inputs stable until ready is seen. The cycle after ready, en may be deasserted or a new request presented. Requests are never sampled in RESP, so the completed request cannot be re-accepted.
- Latency: request seen in IDLE at cycle 0, GRANT at cycle 1, mem_ready in GRANT at cycle 1+W (W = wait states), ready at cycle 2+W. Zero-wait throughput is one transaction per 3 cycles.
- Request dropped mid-GRANT: ignored; the bus cycle completes and ready is still pulsed.
- Loads: rdata is passed through unmodified; sign/size extension is done downstream.

Optional Feature:
- Macro ELBETH_MEM_ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on GRANT entry and increments each GRANT cycle with mem_ready=0. When it reaches TIMEOUT_CYCLES: mem_en<=0, captured rdata=0, error=1, go to RESP. mem_ready on the same cycle as the timeout takes precedence (normal completion).
- Undefined: no counter; GRANT waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset: rst=0 for 2 cycles mid-GRANT_D with mem_ready=0 -> mem_en=0, arb_busy=0, both readies 0; no ready pulse after rst=1.
- Fetch, zero wait: if_imem_en=1, addr=0x100, mem_ready=1 while mem_en=1, mem_rdata=0x00500093 -> mem_addr=0x100, mem_wr=0, mem_data_sel=4'hF; if_imem_ready=1 for exactly one cycle, 2 cycles after request, if_imem_rdata=0x00500093.
- Collision: if_imem_en=1 and exs_dmem_en=1 (store, addr 0x2000, wdata 0xDEADBEEF, data_sel 4'b0011) in the same IDLE cycle -> data granted first, exs_dmem_ready pulses; then fetch granted; if_imem_ready pulses 3 cycles after exs_dmem_ready.
- Wait states: exs load, mem_ready delayed 4 cycles -> mem_* stable for all 5 GRANT cycles; exs_dmem_ready 6 cycles after request.
- Bus error: mem_ready=1 with mem_error=1 on a fetch -> if_imem_ready=1 and if_imem_error=1 in the same cycle.
- Timeout (macro defined, TIMEOUT_CYCLES=8): mem_ready held 0 -> mem_en drops after 8 GRANT cycles; exs_dmem_ready=1, exs_dmem_error=1, exs_dmem_rdata=0. Macro undefined: arb_busy stays 1 after 100 cycles.
